// File: rtl/mem_lsu_if.sv
// Core request/response channel plus the single-cycle word memory bus of the load/store unit.
// slave is the LSU view; master is the core/memory environment view.
interface mem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rstrb;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_rstrb, mem_wdata, mem_wmask
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_rstrb, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/mem_lsu.sv
// RV32I load/store unit: one request at a time, word-aligned bus access with byte-lane
// masking on stores and lane extraction plus sign/zero extension on loads.
module mem_lsu #(
   parameter int unsigned MEM_ADDR_BITS = 10
) (
   input logic       clk,
   input logic       resetn,
   mem_lsu_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_e;

   state_e      state_q, state_d;
   logic [2:0]  f3_q, f3_d;
   logic        we_q, we_d;
   logic [1:0]  lo_q, lo_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_rstrb_q, mem_rstrb_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wmask_q, mem_wmask_d;

   logic        req_err;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;

   always_comb begin
      req_err = 1'b0;
      unique case (bus.req_funct3)
         3'd3, 3'd6, 3'd7: req_err = 1'b1;
         3'd1, 3'd5:       req_err = bus.req_addr[0];
         3'd2:             req_err = (bus.req_addr[1:0] != 2'b00);
         default:          req_err = 1'b0;
      endcase
      if ((bus.req_addr >> MEM_ADDR_BITS) != '0) req_err = 1'b1;
   end

   // Byte lane chosen by both low address bits, halfword lane by bit 1 only.
   always_comb begin
      lane_b = bus.mem_rdata[{lo_q, 3'b000} +: 8];
      lane_h = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      unique case (f3_q)
         3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
         3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
         3'd4:    load_val = {24'h0, lane_b};
         3'd5:    load_val = {16'h0, lane_h};
         default: load_val = bus.mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      f3_d         = f3_q;
      we_d         = we_q;
      lo_d         = lo_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_rstrb_d  = 1'b0;
      mem_wmask_d  = '0;
      unique case (state_q)
         IDLE: if (bus.req_valid) begin
            f3_d = bus.req_funct3;
            we_d = bus.req_we;
            lo_d = bus.req_addr[1:0];
            if (req_err) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = '0;
            end else begin
               state_d    = ACCESS;
               mem_addr_d = {bus.req_addr[31:2], 2'b00};
               if (bus.req_we) begin
                  unique case (bus.req_funct3[1:0])
                     2'd0: begin
                        mem_wmask_d = 4'b0001 << bus.req_addr[1:0];
                        mem_wdata_d = {4{bus.req_wdata[7:0]}};
                     end
                     2'd1: begin
                        mem_wmask_d = 4'b0011 << bus.req_addr[1:0];
                        mem_wdata_d = {2{bus.req_wdata[15:0]}};
                     end
                     default: begin
                        mem_wmask_d = 4'b1111;
                        mem_wdata_d = bus.req_wdata;
                     end
                  endcase
               end else begin
                  mem_rstrb_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (we_q) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
            end else begin
               state_d = RDATA;
            end
         end
         RDATA: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_val;
         end
         RESP: if (bus.resp_ready) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         f3_q         <= '0;
         we_q         <= 1'b0;
         lo_q         <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_rstrb_q  <= 1'b0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
      end else begin
         state_q      <= state_d;
         f3_q         <= f3_d;
         we_q         <= we_d;
         lo_q         <= lo_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_rstrb_q  <= mem_rstrb_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_rstrb  = mem_rstrb_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wmask  = mem_wmask_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, back-pressure and reset sequences, then random
// traffic checked against a byte-array memory model.
module tb_mem_lsu;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   mem_lsu_if bus();
   mem_lsu #(.MEM_ADDR_BITS(10)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

   logic [31:0] mem [256];
   logic [7:0]  ref_mem [1024];
   int unsigned n_pass = 0, n_chk = 0;
   int          rstrb_cnt, wm_cnt;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_wmask;

   // Single-cycle-latency word memory on the bus side.
   always @(posedge clk) begin
      if (bus.mem_rstrb) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      for (int i = 0; i < 4; i++)
         if (bus.mem_wmask[i]) mem[bus.mem_addr[9:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
   end

   always @(negedge clk) begin
      if (bus.mem_rstrb) begin
         rstrb_cnt++;
         last_addr = bus.mem_addr;
      end
      if (bus.mem_wmask != 4'b0000) begin
         wm_cnt++;
         last_addr  = bus.mem_addr;
         last_wmask = bus.mem_wmask;
         last_wdata = bus.mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: memory as a plain byte array, results from the access rules directly.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rd,
                                 output logic e, output int lat);
      int unsigned sz;
      logic [31:0] v;
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      e  = (f3 == 3'd3) || (f3 >= 3'd6) || ((addr % sz) != 0) || (addr >= 32'd1024);
      rd = 32'h0;
      if (e) lat = 1;
      else if (we) begin
         lat = 2;
         for (int unsigned i = 0; i < sz; i++) ref_mem[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
      end else begin
         lat = 3;
         v = 32'h0;
         for (int unsigned i = 0; i < sz; i++) v = v | (32'(ref_mem[addr[9:0] + 10'(i)]) << (8*i));
         if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
         rd = v;
      end
   endfunction

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
      int w;
      @(negedge clk);
      rstrb_cnt = 0; wm_cnt = 0; last_addr = '0; last_wdata = '0; last_wmask = '0;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wdata;
      w = 0;
      while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1 bus.req_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.resp_valid) break;
      end
      if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1 bus.resp_ready = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic [3:0]  exp_wmask;
      logic [31:0] exp_wdata;
   } vec_t;

   initial begin
      vec_t        vt[$];
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat, mlat, seen;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wd;

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[100] = 32'h04030201; mem[101] = 32'h08070605;
      mem[102] = 32'h0C0B0A09; mem[103] = 32'hFF0F0E0D;
      for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i/4][8*(i%4) +: 8];

      bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
      bus.req_wdata = 0; bus.resp_ready = 0;
      resetn = 1'b0;
      #12;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_strobes", {27'd0, bus.mem_rstrb, bus.mem_wmask}, 32'd0);
      #10 resetn = 1'b1;

      //          we  f3  addr   wdata          rdata          err lat wmask    wdata
      vt.push_back('{0, 0, 403, 32'h0,         32'h00000004, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{0, 0, 415, 32'h0,         32'hFFFFFFFF, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{0, 4, 415, 32'h0,         32'h000000FF, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{0, 1, 414, 32'h0,         32'hFFFFFF0F, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{0, 5, 414, 32'h0,         32'h0000FF0F, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{0, 2, 412, 32'h0,         32'hFF0F0E0D, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{0, 0, 406, 32'h0,         32'h00000007, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{1, 0, 801, 32'h123456AB,  32'h0,        0, 2, 4'b0010, 32'hABABABAB});
      vt.push_back('{0, 2, 800, 32'h0,         32'h0000AB00, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{1, 1, 802, 32'h0000BEEF,  32'h0,        0, 2, 4'b1100, 32'hBEEFBEEF});
      vt.push_back('{0, 2, 800, 32'h0,         32'hBEEFAB00, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{1, 2, 804, 32'hDEADBEEF,  32'h0,        0, 2, 4'b1111, 32'hDEADBEEF});
      vt.push_back('{0, 1, 806, 32'h0,         32'hFFFFDEAD, 0, 3, 4'b0000, 32'h0});
      vt.push_back('{0, 2, 402, 32'h0,         32'h0,        1, 1, 4'b0000, 32'h0});
      vt.push_back('{0, 1, 401, 32'h0,         32'h0,        1, 1, 4'b0000, 32'h0});
      vt.push_back('{0, 3, 400, 32'h0,         32'h0,        1, 1, 4'b0000, 32'h0});
      vt.push_back('{0, 2, 1024, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0});
      vt.push_back('{1, 2, 1026, 32'hAAAA5555, 32'h0,        1, 1, 4'b0000, 32'h0});

      foreach (vt[k]) begin
         do_req(vt[k].we, vt[k].f3, vt[k].addr, vt[k].wdata, rd, er, lat);
         model(vt[k].we, vt[k].f3, vt[k].addr, vt[k].wdata, mrd, mer, mlat);
         chk($sformatf("vec%0d_rdata", k), rd, vt[k].exp_rdata);
         chk($sformatf("vec%0d_err", k), 32'(er), 32'(vt[k].exp_err));
         chk($sformatf("vec%0d_lat", k), 32'(lat), 32'(vt[k].exp_lat));
         chk($sformatf("vec%0d_rstrb_cycles", k), 32'(rstrb_cnt),
             (!vt[k].we && !vt[k].exp_err) ? 32'd1 : 32'd0);
         chk($sformatf("vec%0d_wmask_cycles", k), 32'(wm_cnt),
             (vt[k].we && !vt[k].exp_err) ? 32'd1 : 32'd0);
         if (!vt[k].exp_err) chk($sformatf("vec%0d_mem_addr", k), last_addr, vt[k].addr & ~32'd3);
         if (vt[k].we && !vt[k].exp_err) begin
            chk($sformatf("vec%0d_wmask", k), 32'(last_wmask), 32'(vt[k].exp_wmask));
            chk($sformatf("vec%0d_wdata", k), last_wdata, vt[k].exp_wdata);
         end
      end

      // Back-pressure: response held 4 cycles while a second request waits on req_valid.
      @(negedge clk);
      bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'd2; bus.req_addr = 412;
      @(posedge clk); #1;
      bus.req_funct3 = 3'd0; bus.req_addr = 403;
      seen = 0;
      while (seen < 20 && !bus.resp_valid) begin @(negedge clk); seen++; end
      chk("hold_resp_arrives", 32'(bus.resp_valid), 32'd1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_valid", c), 32'(bus.resp_valid), 32'd1);
         chk($sformatf("hold%0d_rdata", c), bus.resp_rdata, 32'hFF0F0E0D);
         chk($sformatf("hold%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1;
      @(posedge clk); #1 bus.resp_ready = 0;
      chk("hs_edge_req_ready", 32'(bus.req_ready), 32'd1);
      chk("hs_edge_resp_valid", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1 bus.req_valid = 0;
      chk("second_accepted", 32'(bus.req_ready), 32'd0);
      seen = 0;
      while (seen < 20 && !bus.resp_valid) begin @(negedge clk); seen++; end
      chk("second_rdata", bus.resp_rdata, 32'h00000004);
      bus.resp_ready = 1;
      @(posedge clk); #1 bus.resp_ready = 0;

      // Randomized traffic against the byte-array model.
      for (int n = 0; n < 200; n++) begin
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0 && addr < 1024) addr[1:0] = 2'b00;
         wd   = $urandom;
         model(we, f3, addr, wd, mrd, mer, mlat);
         do_req(we, f3, addr, wd, rd, er, lat);
         chk($sformatf("rnd%0d_rdata", n), rd, mrd);
         chk($sformatf("rnd%0d_err", n), 32'(er), 32'(mer));
         chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(mlat));
         chk($sformatf("rnd%0d_strobes", n), 32'(rstrb_cnt + wm_cnt), mer ? 32'd0 : 32'd1);
      end

      // Reset during the ACCESS cycle of a store.
      @(negedge clk);
      bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'd2;
      bus.req_addr = 808; bus.req_wdata = 32'h11223344;
      @(posedge clk); #1 bus.req_valid = 0;
      chk("rst_mid_wmask_before", 32'(bus.mem_wmask), 32'hF);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_wmask_dropped", 32'(bus.mem_wmask), 32'd0);
      chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk) resetn = 1'b1;
      chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
      seen = 0;
      repeat (6) begin @(negedge clk); if (bus.resp_valid) seen++; end
      chk("rst_mid_no_resp", 32'(seen), 32'd0);
      chk("rst_mid_mem_untouched", mem[202], {ref_mem[811], ref_mem[810], ref_mem[809], ref_mem[808]});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Initiator (CPU-side) end of the single-cycle-latency word memory bus: mem_addr / mem_rdata / mem_rstrb / mem_wdata / mem_wmask.
- Accepts one RV32I load/store request at a time from the core over a valid/ready handshake.
- Drives a word-aligned bus access: byte-lane write masks and replicated store data for stores, byte/halfword extraction with sign/zero extension for loads.
- Returns the result over a valid/ready response channel; misaligned or out-of-range requests are flagged without touching memory.

Parameters:
- MEM_ADDR_BITS, 10, byte-address width backed by memory (1024 B = 256 words); any request with req_addr[31:MEM_ADDR_BITS] != 0 is out of range.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted on clk edge when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU; others illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bits significant
- resp_valid  out  1  response present, held until resp_ready
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_addr  out  32  byte address, bits [1:0] always 0
- mem_rdata  in  32  read word, valid the cycle after mem_rstrb was sampled
- mem_rstrb  out  1  read strobe
- mem_wdata  out  32  write data
- mem_wmask  out  4  byte-lane write enables

Behaviour:
- All outputs registered. Reset: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_rstrb=0, mem_wdata=0, mem_wmask=0.
- Reset asserted mid-operation drops strobes and mask immediately (asynchronous); the in-flight request is lost and no response is produced.
- States: IDLE, ACCESS, RDATA, RESP.
- IDLE: req_ready=1. On accept, latch funct3, we, addr[1:0].
  - Error check: funct3 in {3,6,7}; halfword with addr[0]=1; word with addr[1:0]!=0; out of range.
  - On error: go to RESP with resp_err=1, resp_rdata=0; no strobe or mask is ever asserted.
  - Otherwise: mem_addr={addr[31:2],2'b00}; go to ACCESS.
    - Load: mem_rstrb=1.
    - Store: mem_wmask = 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH, 1111 for SW; mem_wdata = {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, wdata for SW.
- ACCESS: exactly one cycle; mem_rstrb and mem_wmask return to 0 at its end.
  - Store: go to RESP, resp_valid=1, resp_err=0, resp_rdata=0.
  - Load: go to RDATA.
- RDATA: select the lane by latched addr[1:0] (byte: lane addr[1:0]; half: lane addr[1]), extend per funct3 (0/1 sign-extend, 4/5 zero-extend), register into resp_rdata; go to RESP, resp_valid=1.
- RESP: resp_valid, resp_rdata and resp_err held stable until resp_ready=1; that edge clears resp_valid and returns to IDLE. A new request cannot be accepted on the same edge.
- Latency from accept edge to resp_valid high:
  - store: 2 cycles
  - load: 3 cycles
  - error: 1 cycle
- mem_addr and mem_wdata hold their last value outside ACCESS.

Test Plan:
- Memory words 100..103 = 0x04030201, 0x08070605, 0x0C0B0A09, 0xFF0F0E0D. LB 403 -> rstrb high exactly 1 cycle with mem_addr=400; resp_rdata=0x00000004, err=0, resp_valid 3 cycles after accept.
- LB 415 -> 0xFFFFFFFF; LBU 415 -> 0x000000FF; LH 414 -> 0xFFFFFF0F; LHU 414 -> 0x0000FF0F; LW 412 -> 0xFF0F0E0D.
- SB wdata=0x123456AB to 801 -> one cycle wmask=0010, wdata=0xABABABAB, mem_addr=800, no rstrb; then LW 800 -> 0x0000AB00 (memory pre-zeroed). SH 0xBEEF to 802 -> wmask=1100.
- LW 402, LH 401, funct3=3 at 400, LW 1024 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept; rstrb and wmask never asserted.
- Load with resp_ready low 4 cycles -> resp_valid/resp_rdata stable, req_ready=0 throughout; second request held on req_valid is accepted only the edge after the resp handshake.
- resetn pulsed low during ACCESS of a store -> wmask drops to 0 immediately; after release req_ready=1, resp_valid=0, no response produced.
